// File: rtl/branch_resolver.sv
// Branch resolution stage: turns comparator flags and the branch op into a
// registered outcome, flags mispredicts, holds a flush window, keeps statistics.
//
// state | meaning
// RUN   | normal operation, accepts branches when the output slot is free
// FLUSH | mispredict flush window, flush=1 and no new branches accepted
module branch_resolver #(
   parameter int ADDR_BITS    = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_BITS     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           br_op,
   input  logic                 less_than,
   input  logic                 equal,
   input  logic [ADDR_BITS-1:0] pc,
   input  logic [ADDR_BITS-1:0] target,
   input  logic                 pred_taken,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 taken,
   output logic                 mispredict,
   output logic [ADDR_BITS-1:0] redirect_pc,
   output logic                 flush,
   output logic [CNT_BITS-1:0]  branch_count,
   output logic [CNT_BITS-1:0]  mispredict_count
);

   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] FLUSH = 1'b1;

   localparam logic [2:0] OP_BEQ = 3'b000;
   localparam logic [2:0] OP_BNE = 3'b001;
   localparam logic [2:0] OP_BLT = 3'b010;
   localparam logic [2:0] OP_BGE = 3'b011;
   localparam logic [2:0] OP_BLE = 3'b100;
   localparam logic [2:0] OP_BGT = 3'b101;
   localparam logic [2:0] OP_JMP = 3'b110;

   localparam int FC_BITS = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
   localparam logic [FC_BITS-1:0] FC_LOAD = FC_BITS'(FLUSH_CYCLES);
   localparam logic FLUSH_EN = (FLUSH_CYCLES > 0);

   logic [0:0]           state;
   logic [FC_BITS-1:0]   flushCnt;
   logic                 accept;
   logic                 xfer;
   logic                 takenNext;
   logic                 mispredictNext;
   logic [ADDR_BITS-1:0] redirectNext;

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;
   assign flush    = (state == FLUSH);

   always_comb begin
      takenNext = 1'b0;
      case (br_op)
         OP_BEQ:  takenNext = equal;
         OP_BNE:  takenNext = !equal;
         OP_BLT:  takenNext = less_than;
         OP_BGE:  takenNext = !less_than;
         OP_BLE:  takenNext = less_than || equal;
         OP_BGT:  takenNext = !less_than && !equal;
         OP_JMP:  takenNext = 1'b1;
         default: takenNext = 1'b0;
      endcase
   end

   assign mispredictNext = (takenNext != pred_taken);
   // Not-taken redirect wraps naturally at the address width.
   assign redirectNext   = takenNext ? target : (pc + ADDR_BITS'(4));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid   <= 1'b0;
         taken       <= 1'b0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         taken       <= takenNext;
         mispredict  <= mispredictNext;
         redirect_pc <= redirectNext;
      end else if (xfer) begin
         out_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         flushCnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (accept && mispredictNext && FLUSH_EN) begin
                  state    <= FLUSH;
                  flushCnt <= FC_LOAD;
               end
            end
            default: begin
               // Terminal count of 1 ends the window after FLUSH_CYCLES cycles.
               if (flushCnt <= FC_BITS'(1)) begin
                  state    <= RUN;
                  flushCnt <= '0;
               end else begin
                  flushCnt <= flushCnt - FC_BITS'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (accept) begin
         if (branch_count != '1)
            branch_count <= branch_count + CNT_BITS'(1);
         if (mispredictNext && (mispredict_count != '1))
            mispredict_count <= mispredict_count + CNT_BITS'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: op table, mispredict flush window,
// backpressure, pc+4 wrap and counter saturation (second instance, 2-bit counters).
module tb_branch_resolver;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready, in_ready2;
   logic [2:0]  br_op;
   logic        less_than, equal;
   logic [31:0] pc, target;
   logic        pred_taken;
   logic        out_valid, out_valid2;
   logic        out_ready;
   logic        taken, taken2, mispredict, mispredict2, flush, flush2;
   logic [31:0] redirect_pc, redirect_pc2;
   logic [15:0] branch_count, mispredict_count;
   logic [1:0]  branch_count2, mispredict_count2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   branch_resolver #(.ADDR_BITS(32), .FLUSH_CYCLES(2), .CNT_BITS(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .br_op(br_op), .less_than(less_than), .equal(equal), .pc(pc), .target(target),
      .pred_taken(pred_taken), .out_valid(out_valid), .out_ready(out_ready),
      .taken(taken), .mispredict(mispredict), .redirect_pc(redirect_pc), .flush(flush),
      .branch_count(branch_count), .mispredict_count(mispredict_count));

   branch_resolver #(.ADDR_BITS(32), .FLUSH_CYCLES(2), .CNT_BITS(2)) dutSat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .br_op(br_op), .less_than(less_than), .equal(equal), .pc(pc), .target(target),
      .pred_taken(pred_taken), .out_valid(out_valid2), .out_ready(out_ready),
      .taken(taken2), .mispredict(mispredict2), .redirect_pc(redirect_pc2), .flush(flush2),
      .branch_count(branch_count2), .mispredict_count(mispredict_count2));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic lt, input logic eq,
                        input logic [31:0] p, input logic [31:0] t, input logic pr);
      br_op = op; less_than = lt; equal = eq; pc = p; target = t; pred_taken = pr;
   endtask

   task automatic test_reset;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      tests++; if ({taken, mispredict, flush, redirect_pc, branch_count, mispredict_count} !== '0) begin
         fails++; $display("FAIL rst_outputs got t=%b m=%b f=%b r=%h bc=%0d mc=%0d want all 0",
                           taken, mispredict, flush, redirect_pc, branch_count, mispredict_count); end
      @(posedge clk); #1; reset = 1'b0;
      // mispredict to get into FLUSH with a valid result, then reset mid-window
      drive(3'b000, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tests++; if ({out_valid, flush} !== 2'b11) begin fails++; $display("FAIL rst_pre got v=%b f=%b want 1 1", out_valid, flush); end
      #2 reset = 1'b1;
      #1;
      tests++; if ({out_valid, taken, mispredict, flush, redirect_pc, branch_count, mispredict_count} !== '0) begin
         fails++; $display("FAIL rst_midflush got v=%b t=%b m=%b f=%b r=%h bc=%0d mc=%0d want all 0",
                           out_valid, taken, mispredict, flush, redirect_pc, branch_count, mispredict_count); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_midflush_ready got %b want 1", in_ready); end
      reset = 1'b0;
   endtask

   task automatic test_op_table;
      logic [7:0] tbl [3];
      logic [1:0] lteq [3];
      logic       exp;
      tbl[0] = 8'h6A; lteq[0] = 2'b00;
      tbl[1] = 8'h59; lteq[1] = 2'b01;
      tbl[2] = 8'h56; lteq[2] = 2'b10;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         for (int op = 0; op < 8; op++) begin
            exp = tbl[c][op];
            drive(3'(op), lteq[c][1], lteq[c][0], 32'h100, 32'h200, exp);
            in_valid = 1'b1;
            tick;
            tests++; if ({out_valid, taken, mispredict} !== {1'b1, exp, 1'b0}) begin
               fails++; $display("FAIL op_taken op=%0d lt=%b eq=%b got v=%b t=%b m=%b want 1 %b 0",
                                 op, lteq[c][1], lteq[c][0], out_valid, taken, mispredict, exp); end
            tests++; if (redirect_pc !== (exp ? 32'h200 : 32'h104)) begin
               fails++; $display("FAIL op_redirect op=%0d got %h want %h", op, redirect_pc, exp ? 32'h200 : 32'h104); end
         end
      end
      in_valid = 1'b0;
      tick;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL op_drain got %b want 0", out_valid); end
      tests++; if ({branch_count, mispredict_count} !== {16'd24, 16'd0}) begin
         fails++; $display("FAIL op_counts got bc=%0d mc=%0d want 24 0", branch_count, mispredict_count); end
   endtask

   task automatic test_mispredict;
      out_ready = 1'b1;
      drive(3'b000, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0);
      in_valid = 1'b1;
      tick;
      tests++; if ({out_valid, mispredict, taken} !== 3'b111) begin
         fails++; $display("FAIL mp_result got v=%b m=%b t=%b want 1 1 1", out_valid, mispredict, taken); end
      tests++; if (redirect_pc !== 32'h200) begin fails++; $display("FAIL mp_redirect got %h want 00000200", redirect_pc); end
      tests++; if ({flush, in_ready} !== 2'b10) begin fails++; $display("FAIL mp_flush1 got f=%b r=%b want 1 0", flush, in_ready); end
      // a new branch waits upstream during the window
      drive(3'b110, 1'b0, 1'b0, 32'h300, 32'h400, 1'b1);
      tick;
      tests++; if ({flush, in_ready, out_valid} !== 3'b100) begin
         fails++; $display("FAIL mp_flush2 got f=%b r=%b v=%b want 1 0 0", flush, in_ready, out_valid); end
      tick;
      tests++; if ({flush, in_ready, out_valid} !== 3'b010) begin
         fails++; $display("FAIL mp_flush_end got f=%b r=%b v=%b want 0 1 0", flush, in_ready, out_valid); end
      tick;
      in_valid = 1'b0;
      tests++; if ({out_valid, taken, mispredict, redirect_pc} !== {3'b110, 32'h400}) begin
         fails++; $display("FAIL mp_next got v=%b t=%b m=%b r=%h want 1 1 0 00000400", out_valid, taken, mispredict, redirect_pc); end
      tick;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      drive(3'b010, 1'b1, 1'b0, 32'h100, 32'h200, 1'b1);
      in_valid = 1'b1;
      tick;
      out_ready = 1'b0;
      drive(3'b011, 1'b1, 1'b0, 32'h500, 32'h600, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick;
         tests++; if ({out_valid, taken, in_ready, redirect_pc} !== {3'b110, 32'h200}) begin
            fails++; $display("FAIL bp_hold cyc=%0d got v=%b t=%b r=%b pc=%h want 1 1 0 00000200",
                              i, out_valid, taken, in_ready, redirect_pc); end
      end
      out_ready = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready got %b want 1", in_ready); end
      tick;
      in_valid = 1'b0;
      tests++; if ({out_valid, taken, mispredict, redirect_pc} !== {3'b100, 32'h504}) begin
         fails++; $display("FAIL bp_nobubble got v=%b t=%b m=%b r=%h want 1 0 0 00000504", out_valid, taken, mispredict, redirect_pc); end
      tick;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", out_valid); end
   endtask

   task automatic test_wrap;
      out_ready = 1'b1;
      drive(3'b001, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h200, 1'b0);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tests++; if ({out_valid, taken, mispredict} !== 3'b100) begin
         fails++; $display("FAIL wrap_taken got v=%b t=%b m=%b want 1 0 0", out_valid, taken, mispredict); end
      tests++; if (redirect_pc !== 32'h0) begin fails++; $display("FAIL wrap_redirect got %h want 00000000", redirect_pc); end
      tick;
   endtask

   task automatic test_saturation;
      reset = 1'b1;
      #2 reset = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         drive(3'b000, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0);
         in_valid = 1'b1;
         tick;
         in_valid = 1'b0;
         for (int w = 0; w < 10 && !in_ready; w++) tick;
         tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL sat_wait n=%0d got in_ready=%b want 1", n, in_ready); end
      end
      tests++; if ({branch_count2, mispredict_count2} !== {2'd3, 2'd3}) begin
         fails++; $display("FAIL sat_counts got bc=%0d mc=%0d want 3 3", branch_count2, mispredict_count2); end
      tests++; if ({branch_count, mispredict_count} !== {16'd5, 16'd5}) begin
         fails++; $display("FAIL wide_counts got bc=%0d mc=%0d want 5 5", branch_count, mispredict_count); end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(3'b111, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #12;
      test_reset;
      test_op_table;
      test_mispredict;
      test_back_to_back;
      test_wrap;
      test_saturation;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
